serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Multi-cycle bit-serial subtractor: computes `diff = a - b - bin` one bit per clock, LSB first, with a single-bit borrow register between bit steps. It is the inverse-direction companion to the team's registered ripple adder. It serves area-constrained datapaths that can afford WIDTH+2 cycles per operation, and talks to its controller through a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width; legal range 2..32.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured on the accepting edge.
- `b`  in  WIDTH  subtrahend; captured on the accepting edge.
- `bin`  in  1  borrow-in; captured on the accepting edge.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; results valid.
- `diff`  out  WIDTH  result, `a - b - bin` mod 2^WIDTH.
- `bout`  out  1  borrow-out; 1 iff unsigned `a < b + bin`.
- `ovf`  out  1  two's-complement overflow of the signed subtraction.

## Operation
- **States:** IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE after WIDTH bit steps.
  - DONE → IDLE unconditionally.
- **Accept:** in IDLE with `start`=1, the edge latches `a`, `b` and `bin` into internal shift registers. The borrow register loads `bin` and the bit counter clears to 0.
- **Bit step:** each RUN edge handles bit i.
  - `d_i = a_i ^ b_i ^ br`
  - `br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)`
  - `d_i` shifts into the result shift register from the MSB side. The operand registers shift right. The counter increments.
- **Completion:** the last RUN edge (counter = WIDTH-1) does the following.
  - Writes `diff` from the assembled result.
  - Sets `bout` = final `br'`.
  - Sets `ovf = (a[W-1] != b[W-1]) & (d[W-1] != a[W-1])`, using the captured operand MSBs.
  - Enters DONE.
- **Output hold:** `diff`, `bout` and `ovf` change only at completion. They hold their values through IDLE and through the next operation until its completion.
- **`start` outside IDLE:** ignored in RUN and DONE. It is not queued.
- **`done` and `busy`:** both are registered. `done`=1 only in DONE; `busy`=1 only in RUN.
- **Reset:** values on reset, including reset mid-operation:
  - state → IDLE
  - `busy`, `done`, `bout`, `ovf` → 0
  - `diff` → 0
  - internal registers → 0

  Any operation in flight is abandoned and no `done` is produced.

## Timing
- Call the accepting edge E.
- `busy` rises after E and falls after E+WIDTH.
- `diff`, `bout` and `ovf` are valid and `done` rises after E+WIDTH. `done` falls after E+WIDTH+1.
- Latency from accept to `done` is WIDTH cycles (8 at the default).
- Earliest next accept is edge E+WIDTH+2, giving throughput of one operation per WIDTH+2 cycles.
- Operands may change freely after E.
- No combinational path from inputs to outputs.

## Structure
- **Shared package `serial_arith_pkg`:**
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - counter width function `clog2(WIDTH)`.
- **Sub-module `full_subtractor`:** combinational one-bit cell (`a`, `b`, `bin` → `d`, `bout`). It is instantiated once and reused every step. The top-level holds the FSM, counter, shift registers and output registers.

## Test plan
- 0x50 − 0x30, bin=0, start at E → `busy` for 8 cycles; after E+8: `diff`=0x20, `bout`=0, `ovf`=0, `done` for exactly 1 cycle.
- 0x00 − 0x01, bin=0 → `diff`=0xFF, `bout`=1, `ovf`=0. Then 0x05 − 0x05, bin=1 → `diff`=0xFF, `bout`=1, `ovf`=0.
- 0x80 − 0x01 → `diff`=0x7F, `bout`=0, `ovf`=1. 0x7F − 0xFF → `diff`=0x80, `bout`=1, `ovf`=1.
- `start` re-pulsed with new operands at E+3 and held high through DONE → ignored: result from the original operands, a single `done`. A new accept happens only at E+10, with `done` after E+18.
- `rst` low at E+4 → `busy`, `done`, `diff`, `bout`, `ovf` all 0 immediately (asynchronously), and no `done` follows. After `rst` release, a fresh 0x50 − 0x30 completes normally with 0x20.
- Randomized: 1000 operations with random `a`, `b`, `bin` and random idle gaps, checked against the reference model `(a - b - bin) & 0xFF` plus the borrow and overflow equations above.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// ============================================================================
// Module      : serial_arith_pkg
// Description : Shared state encoding and sizing helper for the bit-serial
//               arithmetic blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : serial_arith_pkg

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module      : full_subtractor
// Description : Combinational one-bit subtractor cell: d = a - b - bin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic a_xor_b;

    assign a_xor_b = a ^ b;
    assign d       = a_xor_b ^ bin;
    assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule : full_subtractor

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial subtractor, diff = a - b - bin, LSB first, one bit
//               per clock with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int               CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             br;
    logic             a_msb;
    logic             b_msb;

    logic             step_d;
    logic             step_bout;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (step_d),
        .bout (step_bout)
    );

    // New bit enters at the MSB; after the final step this is the full result.
    assign res_next = {step_d, res_sh};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= step_bout;
                    res_sh <= res_next[WIDTH-1:1];
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= res_next;
                        bout  <= step_bout;
                        ovf   <= (a_msb != b_msb) && (step_d != a_msb);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule : serial_subtractor

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Directed and randomized self-checking bench for serial_subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation with timing checks; caller sits #1 after an edge in IDLE.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                         input logic [W-1:0] ed, input logic ebo, input logic eov);
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        a     = ta;
        b     = tb;
        bin   = tbin;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~ta;
        b     = ~tb;
        bin   = ~tbin;
        for (int k = 0; k < W; k++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            tick();
        end
        chk("busy_cycles", busy_cnt, W);
        chk("early_done", done_cnt, 0);
        chk("done_high", done, 1'b1);
        chk("busy_low", busy, 1'b0);
        chk("diff", diff, ed);
        chk("bout", bout, ebo);
        chk("ovf", ovf, eov);
        tick();
        chk("done_pulse_end", done, 1'b0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;
        logic [W:0]   full;
        int           dcnt;

        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_bout", bout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst = 1'b1;
        repeat (2) tick();

        do_op(8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0);
        do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        repeat (3) tick();
        chk("hold_diff_idle", diff, 8'hFF);
        chk("hold_bout_idle", bout, 1'b1);
        do_op(8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0);
        do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // start re-pulsed during RUN and held through DONE
        a = 8'h50; b = 8'h30; bin = 1'b0; start = 1'b1;
        tick();                                   // E
        start = 1'b0;
        repeat (3) tick();                        // E+3
        a = 8'h11; b = 8'h22; bin = 1'b0; start = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin         // E+4 .. E+7
            tick();
            if (done === 1'b1) dcnt++;
        end
        chk("repulse_no_early_done", dcnt, 0);
        chk("repulse_hold_diff_run", diff, 8'h80);
        tick();                                   // E+8
        chk("repulse_done", done, 1'b1);
        chk("repulse_diff", diff, 8'h20);
        tick();                                   // E+9
        chk("repulse_done_end", done, 1'b0);
        chk("repulse_idle_busy", busy, 1'b0);
        tick();                                   // E+10 accepts
        chk("repulse_accept_busy", busy, 1'b1);
        start = 1'b0;
        repeat (7) tick();                        // E+17
        chk("repulse_busy_e17", busy, 1'b1);
        chk("repulse_hold_diff", diff, 8'h20);
        tick();                                   // E+18
        chk("second_done", done, 1'b1);
        chk("second_diff", diff, 8'hEF);
        chk("second_bout", bout, 1'b1);
        chk("second_ovf", ovf, 1'b0);
        tick();

        // asynchronous reset mid-operation
        a = 8'h00; b = 8'h01; bin = 1'b0; start = 1'b1;
        tick();                                   // E
        start = 1'b0;
        repeat (4) tick();                        // E+4
        #2 rst = 1'b0;
        #1;
        chk("async_busy", busy, 1'b0);
        chk("async_done", done, 1'b0);
        chk("async_diff", diff, 8'h00);
        chk("async_bout", bout, 1'b0);
        chk("async_ovf", ovf, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        chk("no_done_after_reset", dcnt, 0);
        do_op(8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            ra   = W'($urandom_range(0, 255));
            rb   = W'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            do_op(ra, rb, rbin, full[W-1:0], full[W],
                  (ra[W-1] != rb[W-1]) && (full[W-1] != ra[W-1]));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_subtractor

`default_nettype wire
